// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder with a start/busy/done handshake.
// Operands are captured in parallel and summed LSB-first, one bit per clock,
// through a full-adder cell built from two half adders and an OR, with a
// carry flip-flop closing the loop. Sum/Carry are registered and held
// until the next completion.
// Optional feature macro: SERIAL_ADDER_OVERFLOW_EN adds a registered
// two's-complement Overflow output updated alongside Sum/Carry.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             Overflow
`endif
);

  // Bit counter must hold WIDTH-1; a single-bit operand still needs 1 bit.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic             c_reg;
  logic [CW-1:0]    cnt_reg;
  logic             last_bit;

  logic             ha0_s;
  logic             ha0_c;
  logic             ha1_s;
  logic             ha1_c;
  logic             s_bit;
  logic             cout;
  logic [WIDTH-1:0] sum_shift;

  // Full-adder cell: first half adder combines the operand bits, the second
  // folds in the stored carry; either half-adder carry produces carry-out.
  assign ha0_s = a_sr_reg[0] ^ b_sr_reg[0];
  assign ha0_c = a_sr_reg[0] & b_sr_reg[0];
  assign ha1_s = ha0_s ^ c_reg;
  assign ha1_c = ha0_s & c_reg;
  assign s_bit = ha1_s;
  assign cout  = ha0_c | ha1_c;

  assign last_bit = (cnt_reg == CNT_LAST);

  // The result shift register only needs the WIDTH-1 bits already produced;
  // the bit computed this cycle is concatenated on top. A 1-bit adder needs
  // no storage at all.
  generate
    if (WIDTH == 1) begin : g_single
      assign sum_shift = s_bit;
    end else begin : g_multi
      logic [WIDTH-2:0] s_sr_reg;

      assign sum_shift = {s_bit, s_sr_reg};

      // Collect sum bits MSB-in while running; cleared only by reset since
      // every bit is overwritten before the result is taken.
      always_ff @(posedge clk) begin
        if (rst) begin
          s_sr_reg <= '0;
        end else if (state_reg == RUN) begin
          s_sr_reg <= sum_shift[WIDTH-1:1];
        end
      end
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: start only matters in IDLE; DONE lasts one cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture operands on accepted start, shift one bit per RUN
  // cycle, and publish the result on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_reg <= '0;
      b_sr_reg <= '0;
      c_reg    <= 1'b0;
      cnt_reg  <= '0;
      Sum      <= '0;
      Carry    <= 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      Overflow <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sr_reg <= A;
            b_sr_reg <= B;
            c_reg    <= Cin;
            cnt_reg  <= '0;
          end
        end
        RUN: begin
          a_sr_reg <= a_sr_reg >> 1;
          b_sr_reg <= b_sr_reg >> 1;
          c_reg    <= cout;
          cnt_reg  <= cnt_reg + 1'b1;
          if (last_bit) begin
            Sum      <= sum_shift;
            Carry    <= cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            // c_reg is the carry into the MSB, cout the carry out of it.
            Overflow <= c_reg ^ cout;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);

endmodule
